demux1x4_seq: RTL and testbench
===============================

# demux1x4_seq

Registered 1-to-4 demultiplexer with lane sequencing: the receive-side counterpart of the team's 4x1 select mux. Each accepted input beat is steered to one of four output lanes, chosen either by an external 2-bit select (s1, s0), using the same encoding as the mux, or by an internal round-robin pointer. The block tracks which lanes have been written in the current frame and strobes when all four are filled. It sits between a serialised data source and four parallel consumers.

## Interface
- W, default 1: data width of d_in and of each output lane.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- d_in  input  W  input data beat.
- d_valid  input  1  beat qualifier; a beat is accepted on any rising edge with d_valid=1.
- auto  input  1  1 selects the internal round-robin pointer; 0 selects external select {s1,s0}.
- s1, s0  input  1 each  external lane select; lane = {s1,s0}; 00→o0, 01→o1, 10→o2, 11→o3.
- o0, o1, o2, o3  output  W each  registered lane data.
- o_valid  output  4  one-cycle pulse per lane; bit k is set in the cycle after lane k captures a beat.
- frame_done  output  1  one-cycle pulse; all four lanes written since the last frame_done or clear.
- lane_ptr  output  2  current round-robin pointer; meaningful in auto mode.

## Operation
- Target lane per cycle:
  - auto=1: lane_ptr.
  - auto=0: {s1,s0}.
- Accepted beat (d_valid=1):
  - the target lane register loads d_in;
  - o_valid[target] is set for one cycle;
  - fill mask bit [target] is set.
- Auto pointer: increments by 1 per accepted beat in auto mode and wraps 3→0. In manual mode it holds its value.
- Fill mask (internal, 4 bits):
  - when the update makes the mask 1111, frame_done pulses and the mask clears to 0000 in the same edge;
  - writing an already-set lane again in manual mode leaves its mask bit set; it is not counted twice.
- Mode change: auto is registered internally. On any cycle where auto differs from its registered value:
  - pointer and mask clear to 0;
  - a beat in that cycle is still accepted, using the new mode, with pointer treated as 0 and mask as empty.
- No back-pressure. Every valid beat is accepted.
- Reset (rst_n=0 at an edge), including mid-frame:
  - o0..o3, o_valid, frame_done, lane_ptr, mask and the registered auto all go to 0;
  - any beat in that cycle is dropped.

## Timing
- Latency is one cycle. A beat sampled at edge N appears on o_k and o_valid[k] after edge N.
- frame_done is coincident with the o_valid pulse of the completing beat.
- o_valid and frame_done are high for exactly one cycle per event. Back-to-back beats produce back-to-back pulses on successive lanes.
- Auto mode, continuous valid: frame_done every 4th cycle; lane_ptr sequence 0,1,2,3,0.
- Simultaneous mode change and beat: handled as described in Operation; mask clear takes priority over the old mask.
- Reset values of all outputs are 0.

## Configuration
- HOLD_LAST_EN
  - Defined: a lane register holds its last captured value until rewritten (parallel-collect behaviour).
  - Undefined: every lane not written at a given edge loads 0, so exactly one lane is non-zero after a valid beat and all lanes are 0 after an idle cycle. This is a registered version of the pure demux truth table.
- o_valid, frame_done, pointer and mask behaviour are identical in both builds.

## Test plan
- Reset, then manual mode, W=1: drive {s1,s0}=00,01,10,11 with d_in=1 and d_valid=1 on four consecutive cycles.
  - o_valid pulses 0001, 0010, 0100, 1000.
  - frame_done pulses on the 4th cycle only.
  - HOLD_LAST_EN: o0..o3 all 1 at the end. Undefined: only o3=1 at the end.
- Auto mode, W=4: stream 0xA,0xB,0xC,0xD,0xE with continuous valid.
  - Lanes receive A,B,C,D in order; frame_done after D.
  - 0xE lands in o0; lane_ptr=1 afterwards.
- Manual mode: write lanes 2,2,0,1,3.
  - No frame_done before the lane-3 write; frame_done pulses on that write; mask is then empty.
- Gapped valid in auto mode: d_valid=1,0,0,1.
  - lane_ptr advances only on the valid beats (0→1, held, held, 1→2).
  - No o_valid pulse during the idle cycles.
- Mode change: auto mode with two beats accepted (lane_ptr=2), then switch auto 1→0 with {s1,s0}=11 and a beat in the same cycle.
  - o3 is captured; mask=1000; lane_ptr=0.
- Reset mid-frame: rst_n=0 for one cycle after three auto-mode beats while d_valid=1.
  - All outputs 0 and that beat dropped.
  - Next four auto-mode beats fill lanes 0..3 and frame_done fires on the 4th.

Source files
------------

// File: rtl/demux1x4_seq_if.sv
// Bus between a serial beat source and the 1-to-4 demux.
// Handshake: a beat transfers on every rising clk edge where d_valid=1;
// there is no ready, the demux never back-pressures. o_valid[k] is a
// one-cycle pulse in the cycle after lane k captured a beat.
// fill_mask is a debug view of the demux's internal frame-fill state.
interface demux1x4_seq_if #(
    parameter int W = 1
);
    logic [W-1:0] d_in;
    logic         d_valid;
    logic         auto;
    logic         s1;
    logic         s0;
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [W-1:0] o3;
    logic [3:0]   o_valid;
    logic         frame_done;
    logic [1:0]   lane_ptr;
    logic [3:0]   fill_mask;

    // Source side: drives beats, observes lanes.
    modport master (
        output d_in, d_valid, auto, s1, s0,
        input  o0, o1, o2, o3, o_valid, frame_done, lane_ptr, fill_mask
    );

    // Demux side.
    modport slave (
        input  d_in, d_valid, auto, s1, s0,
        output o0, o1, o2, o3, o_valid, frame_done, lane_ptr, fill_mask
    );
endinterface

// File: rtl/demux1x4_seq.sv
// Registered 1-to-4 demultiplexer with lane sequencing.
// Each valid beat is steered to one lane chosen by {s1,s0} (manual) or by
// an internal round-robin pointer (auto). A 4-bit fill mask tracks lanes
// written in the current frame; frame_done pulses when all four are filled.
// Build option HOLD_LAST_EN: when defined, lanes keep their last captured
// value; when undefined, unwritten lanes load 0 on every edge.
module demux1x4_seq #(
    parameter int W = 1
) (
    input logic          clk,
    input logic          rst_n,
    demux1x4_seq_if.slave bus
);

    logic [W-1:0] lane_q [4];
    logic [W-1:0] lane_d [4];
    logic [3:0]   o_valid_q;
    logic [3:0]   o_valid_d;
    logic         frame_done_q;
    logic         frame_done_d;
    logic [1:0]   ptr_q;
    logic [1:0]   ptr_d;
    logic [3:0]   mask_q;
    logic [3:0]   mask_d;
    logic         auto_q;

    logic         mode_chg;
    logic [1:0]   ptr_eff;
    logic [3:0]   mask_eff;
    logic [1:0]   target;
    logic [3:0]   wr_hot;
    logic [3:0]   mask_upd;

    // Target selection; a mode change restarts the frame with pointer 0 and
    // an empty mask, and a beat in that same cycle already sees the restart.
    always_comb begin
        mode_chg = bus.auto != auto_q;
        ptr_eff  = mode_chg ? 2'd0 : ptr_q;
        mask_eff = mode_chg ? 4'd0 : mask_q;
        target   = bus.auto ? ptr_eff : {bus.s1, bus.s0};
        wr_hot   = bus.d_valid ? (4'b0001 << target) : 4'b0000;
        mask_upd = mask_eff | wr_hot;
    end

    // Next-state for pointer, mask, strobes and lane data.
    always_comb begin
        o_valid_d    = wr_hot;
        frame_done_d = 1'b0;
        mask_d       = mask_upd;
        ptr_d        = ptr_eff;
        if (bus.d_valid && bus.auto) begin
            ptr_d = ptr_eff + 2'd1;
        end
        if (mask_upd == 4'b1111) begin
            frame_done_d = 1'b1;
            mask_d       = 4'b0000;
        end
        for (int k = 0; k < 4; k++) begin
`ifdef HOLD_LAST_EN
            lane_d[k] = wr_hot[k] ? bus.d_in : lane_q[k];
`else
            lane_d[k] = wr_hot[k] ? bus.d_in : '0;
`endif
        end
    end

    // State registers; reset clears everything and drops any beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                lane_q[k] <= '0;
            end
            o_valid_q    <= 4'b0000;
            frame_done_q <= 1'b0;
            ptr_q        <= 2'd0;
            mask_q       <= 4'b0000;
            auto_q       <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                lane_q[k] <= lane_d[k];
            end
            o_valid_q    <= o_valid_d;
            frame_done_q <= frame_done_d;
            ptr_q        <= ptr_d;
            mask_q       <= mask_d;
            auto_q       <= bus.auto;
        end
    end

    assign bus.o0         = lane_q[0];
    assign bus.o1         = lane_q[1];
    assign bus.o2         = lane_q[2];
    assign bus.o3         = lane_q[3];
    assign bus.o_valid    = o_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.lane_ptr   = ptr_q;
    assign bus.fill_mask  = mask_q;

endmodule

// File: tb/tb_demux1x4_seq.sv
// Bench for demux1x4_seq: directed beats push hand-computed responses into
// a queue; a monitor pops and compares whenever o_valid is non-zero.
module tb_demux1x4_seq;

    localparam int W  = 4;
    localparam int PW = 4 + 1 + W + 2 + 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [PW-1:0] exp_q[$];

    demux1x4_seq_if #(.W(W)) dif ();

    demux1x4_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_of(input logic [3:0] ov);
        case (ov)
            4'b0001: lane_of = dif.o0;
            4'b0010: lane_of = dif.o1;
            4'b0100: lane_of = dif.o2;
            4'b1000: lane_of = dif.o3;
            default: lane_of = 'x;
        endcase
    endfunction

    // Monitor: compare each presented beat against the queue head
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (dif.o_valid != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: o_valid=%b with empty queue", dif.o_valid);
            end else begin
                e = exp_q.pop_front();
                chk("o_valid",    {28'd0, dif.o_valid},    {28'd0, e[PW-1 -: 4]});
                chk("frame_done", {31'd0, dif.frame_done}, {31'd0, e[PW-5]});
                chk("lane_data",  {28'd0, lane_of(e[PW-1 -: 4])}, {28'd0, e[PW-6 -: W]});
                chk("lane_ptr",   {30'd0, dif.lane_ptr},   {30'd0, e[5:4]});
                chk("fill_mask",  {28'd0, dif.fill_mask},  {28'd0, e[3:0]});
`ifndef HOLD_LAST_EN
                chk("other_lanes_zero",
                    {16'd0, dif.o0, dif.o1, dif.o2, dif.o3} & ~{16'd0,
                        {W{e[PW-4]}}, {W{e[PW-3]}}, {W{e[PW-2]}}, {W{e[PW-1]}}},
                    32'd0);
`endif
            end
        end else begin
            chk("idle_frame_done", {31'd0, dif.frame_done}, 32'd0);
`ifndef HOLD_LAST_EN
            chk("idle_lanes_zero", {16'd0, dif.o0, dif.o1, dif.o2, dif.o3}, 32'd0);
`endif
        end
    end

    // Driver tasks
    task automatic beat(input logic a, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [3:0] ov, input logic fd,
                        input logic [1:0] ptr, input logic [3:0] mask);
        @(negedge clk);
        dif.auto    = a;
        dif.s1      = sel[1];
        dif.s0      = sel[0];
        dif.d_in    = d;
        dif.d_valid = 1'b1;
        exp_q.push_back({ov, fd, d, ptr, mask});
    endtask

    // Drive an idle cycle and check the state left by the previous edge.
    task automatic idle_check(input string name, input logic [1:0] ptr, input logic [3:0] mask);
        @(negedge clk);
        dif.d_valid = 1'b0;
        chk({name, "_ptr"},  {30'd0, dif.lane_ptr},  {30'd0, ptr});
        chk({name, "_mask"}, {28'd0, dif.fill_mask}, {28'd0, mask});
    endtask

    task automatic check_lanes(input string name, input logic [4*W-1:0] exp);
        chk(name, {16'd0, dif.o0, dif.o1, dif.o2, dif.o3}, {16'd0, exp});
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_lanes"},   {16'd0, dif.o0, dif.o1, dif.o2, dif.o3}, 32'd0);
        chk({name, "_o_valid"}, {28'd0, dif.o_valid},    32'd0);
        chk({name, "_fd"},      {31'd0, dif.frame_done}, 32'd0);
        chk({name, "_ptr"},     {30'd0, dif.lane_ptr},   32'd0);
        chk({name, "_mask"},    {28'd0, dif.fill_mask},  32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        dif.d_in    = '0;
        dif.d_valid = 1'b0;
        dif.auto    = 1'b0;
        dif.s1      = 1'b0;
        dif.s0      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Manual mode, lanes 0..3 with d=1
        beat(1'b0, 2'd0, 4'h1, 4'b0001, 1'b0, 2'd0, 4'b0001);
        beat(1'b0, 2'd1, 4'h1, 4'b0010, 1'b0, 2'd0, 4'b0011);
        beat(1'b0, 2'd2, 4'h1, 4'b0100, 1'b0, 2'd0, 4'b0111);
        beat(1'b0, 2'd3, 4'h1, 4'b1000, 1'b1, 2'd0, 4'b0000);
        idle_check("manual_end", 2'd0, 4'b0000);
`ifdef HOLD_LAST_EN
        check_lanes("manual_lanes", {4'h1, 4'h1, 4'h1, 4'h1});
`else
        check_lanes("manual_lanes", {4'h0, 4'h0, 4'h0, 4'h1});
`endif

        // Auto mode stream A..E
        beat(1'b1, 2'd0, 4'hA, 4'b0001, 1'b0, 2'd1, 4'b0001);
        beat(1'b1, 2'd0, 4'hB, 4'b0010, 1'b0, 2'd2, 4'b0011);
        beat(1'b1, 2'd0, 4'hC, 4'b0100, 1'b0, 2'd3, 4'b0111);
        beat(1'b1, 2'd0, 4'hD, 4'b1000, 1'b1, 2'd0, 4'b0000);
        beat(1'b1, 2'd0, 4'hE, 4'b0001, 1'b0, 2'd1, 4'b0001);
        idle_check("auto_end", 2'd1, 4'b0001);
`ifdef HOLD_LAST_EN
        check_lanes("auto_lanes", {4'hE, 4'hB, 4'hC, 4'hD});
`else
        check_lanes("auto_lanes", {4'hE, 4'h0, 4'h0, 4'h0});
`endif

        // Manual lanes 2,2,0,1,3 (switch from auto clears the mask)
        beat(1'b0, 2'd2, 4'h3, 4'b0100, 1'b0, 2'd0, 4'b0100);
        beat(1'b0, 2'd2, 4'h4, 4'b0100, 1'b0, 2'd0, 4'b0100);
        beat(1'b0, 2'd0, 4'h5, 4'b0001, 1'b0, 2'd0, 4'b0101);
        beat(1'b0, 2'd1, 4'h6, 4'b0010, 1'b0, 2'd0, 4'b0111);
        beat(1'b0, 2'd3, 4'h7, 4'b1000, 1'b1, 2'd0, 4'b0000);
        idle_check("repeat_end", 2'd0, 4'b0000);

        // Gapped valid in auto mode: 1,0,0,1
        beat(1'b1, 2'd0, 4'h8, 4'b0001, 1'b0, 2'd1, 4'b0001);
        idle_check("gap1", 2'd1, 4'b0001);
        idle_check("gap2", 2'd1, 4'b0001);
        beat(1'b1, 2'd0, 4'h9, 4'b0010, 1'b0, 2'd2, 4'b0011);

        // Mode change 1->0 with a beat to lane 3 in the same cycle
        beat(1'b0, 2'd3, 4'h6, 4'b1000, 1'b0, 2'd0, 4'b1000);
        idle_check("mode_chg", 2'd0, 4'b1000);

        // Reset mid-frame after three auto beats, with a beat present
        beat(1'b1, 2'd0, 4'h1, 4'b0001, 1'b0, 2'd1, 4'b0001);
        beat(1'b1, 2'd0, 4'h2, 4'b0010, 1'b0, 2'd2, 4'b0011);
        beat(1'b1, 2'd0, 4'h3, 4'b0100, 1'b0, 2'd3, 4'b0111);
        @(negedge clk);
        rst_n       = 1'b0;
        dif.d_in    = 4'hF;
        dif.d_valid = 1'b1;
        @(negedge clk);
        rst_n       = 1'b1;
        dif.d_valid = 1'b0;
        check_all_zero("mid_reset");
        beat(1'b1, 2'd0, 4'h4, 4'b0001, 1'b0, 2'd1, 4'b0001);
        beat(1'b1, 2'd0, 4'h5, 4'b0010, 1'b0, 2'd2, 4'b0011);
        beat(1'b1, 2'd0, 4'h6, 4'b0100, 1'b0, 2'd3, 4'b0111);
        beat(1'b1, 2'd0, 4'h7, 4'b1000, 1'b1, 2'd0, 4'b0000);
        idle_check("post_reset", 2'd0, 4'b0000);

        // Drain and report
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
